// File: rtl/vcfg_pkg.sv
// Shared types and encodings for the vector-configuration controller.
package vcfg_pkg;

  typedef enum logic [1:0] {
    CFG_VSETVLI     = 2'b00,
    CFG_VSETVLI_ALT = 2'b01,
    CFG_VSETVL      = 2'b10,
    CFG_VSETIVLI    = 2'b11
  } cfg_type_e;

  // rsvd collapses vtype[XLEN-2:8] to a single "reserved bit set" flag
  typedef struct packed {
    logic       vill;
    logic       rsvd;
    logic       vma;
    logic       vta;
    logic [2:0] vsew;
    logic [2:0] vlmul;
  } vtype_t;

  localparam logic [2:0] VSEW_E8  = 3'd0;
  localparam logic [2:0] VSEW_E16 = 3'd1;
  localparam logic [2:0] VSEW_E32 = 3'd2;
  localparam logic [2:0] VSEW_E64 = 3'd3;

  localparam logic [2:0] VLMUL_M1   = 3'd0;
  localparam logic [2:0] VLMUL_M2   = 3'd1;
  localparam logic [2:0] VLMUL_M4   = 3'd2;
  localparam logic [2:0] VLMUL_M8   = 3'd3;
  localparam logic [2:0] VLMUL_RSVD = 3'd4;
  localparam logic [2:0] VLMUL_MF8  = 3'd5;
  localparam logic [2:0] VLMUL_MF4  = 3'd6;
  localparam logic [2:0] VLMUL_MF2  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_RESP
  } state_e;

endpackage

// File: rtl/vcfg_vlmax.sv
// Combinational VLMAX from SEW/LMUL plus the SEW/LMUL legality check.
module vcfg_vlmax import vcfg_pkg::*; #(
  parameter int VLEN         = 1024,
  parameter int ELEN         = 64,
  parameter int FRAC_LMUL_EN = 1,
  parameter int VL_BITS      = $clog2(VLEN) + 1
) (
  input  logic [2:0]         vsew,
  input  logic [2:0]         vlmul,
  output logic [VL_BITS-1:0] vlmax,
  output logic               vill_sew_lmul
);

  localparam int                 ELEN_LOG = $clog2(ELEN) - 3;
  localparam logic [VL_BITS-1:0] VLEN_E8  = VL_BITS'(VLEN / 8);

  logic               frac;
  logic [1:0]         fshift;
  logic [VL_BITS-1:0] base;

  always_comb begin
    frac   = vlmul[2] && (vlmul != VLMUL_RSVD);
    // mf8/mf4/mf2 (5/6/7) divide by 2^(8-vlmul) = 2^3/2^2/2^1
    fshift = (~vlmul[1:0]) + 2'd1;
    base   = VLEN_E8 >> vsew;
    vlmax  = frac ? (base >> fshift) : (base << vlmul[1:0]);
    vill_sew_lmul = (vlmul == VLMUL_RSVD)
                 || ({1'b0, vsew} > 4'(ELEN_LOG))
                 || (frac && (FRAC_LMUL_EN == 0))
                 || (frac && (({1'b0, vsew} + {2'b00, fshift}) > 4'(ELEN_LOG)))
                 || (vlmax == '0);
    if (vill_sew_lmul) vlmax = '0;
  end

endmodule

// File: rtl/vcfg_ctrl.sv
// vsetvl/vsetvli/vsetivli controller: FSM, AVL select, clamp, architectural vl/vtype.
module vcfg_ctrl import vcfg_pkg::*; #(
  parameter int XLEN         = 32,
  parameter int VLEN         = 1024,
  parameter int ELEN         = 64,
  parameter int FRAC_LMUL_EN = 1,
  parameter int VL_BITS      = $clog2(VLEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_type,
  input  logic               req_rs1_x0,
  input  logic               req_rd_x0,
  input  logic [XLEN-1:0]    req_avl,
  input  logic [XLEN-1:0]    req_vtype,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [XLEN-1:0]    resp_vl,
  output logic               cfg_busy,
  output logic [VL_BITS-1:0] vl,
  output logic [2:0]         vsew,
  output logic [2:0]         vlmul,
  output logic               vta,
  output logic               vma,
  output logic               vill
);

  localparam int CW = (XLEN > VL_BITS) ? XLEN : VL_BITS;

  state_e             state_q, state_d;
  cfg_type_e          typ_q;
  logic               rs1_x0_q, rd_x0_q;
  logic [XLEN-1:0]    avl_q, vt_raw_q;
  logic [VL_BITS-1:0] vl_q, vl_d;
  logic [2:0]         vsew_q, vsew_d, vlmul_q, vlmul_d;
  logic               vta_q, vta_d, vma_q, vma_d, vill_q, vill_d;
  vtype_t             nvt;
  logic [VL_BITS-1:0] new_vlmax, old_vlmax;
  logic               new_bad, old_bad, keep;
  logic [CW-1:0]      avl_w, vlmax_w;

  // New vtype drives one instance, the architectural vtype the other
  vcfg_vlmax #(.VLEN(VLEN), .ELEN(ELEN), .FRAC_LMUL_EN(FRAC_LMUL_EN), .VL_BITS(VL_BITS)) u_new (
    .vsew(nvt.vsew), .vlmul(nvt.vlmul), .vlmax(new_vlmax), .vill_sew_lmul(new_bad));
  vcfg_vlmax #(.VLEN(VLEN), .ELEN(ELEN), .FRAC_LMUL_EN(FRAC_LMUL_EN), .VL_BITS(VL_BITS)) u_old (
    .vsew(vsew_q), .vlmul(vlmul_q), .vlmax(old_vlmax), .vill_sew_lmul(old_bad));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req_valid)  state_d = ST_CALC;
      ST_CALC: state_d = rd_x0_q ? ST_IDLE : ST_RESP;
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    cfg_busy   = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: req_ready  = 1'b1;
      ST_CALC: cfg_busy   = 1'b1;
      ST_RESP: resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      typ_q    <= CFG_VSETVLI;
      rs1_x0_q <= 1'b0;
      rd_x0_q  <= 1'b0;
      avl_q    <= '0;
      vt_raw_q <= '0;
    end else if (state_q == ST_IDLE && req_valid) begin
      typ_q    <= cfg_type_e'(req_type);
      rs1_x0_q <= req_rs1_x0;
      rd_x0_q  <= req_rd_x0;
      avl_q    <= req_avl;
      vt_raw_q <= req_vtype;
    end
  end

  always_comb begin
    nvt.vill  = vt_raw_q[XLEN-1];
    nvt.rsvd  = |vt_raw_q[XLEN-2:8];
    nvt.vma   = vt_raw_q[7];
    nvt.vta   = vt_raw_q[6];
    nvt.vsew  = vt_raw_q[5:3];
    nvt.vlmul = vt_raw_q[2:0];
  end

  // Clamp compares at full width so large AVLs never wrap below VLMAX
  always_comb begin
    keep    = (typ_q != CFG_VSETIVLI) && rs1_x0_q && rd_x0_q;
    vlmax_w = CW'(new_vlmax);
    avl_w   = ((typ_q == CFG_VSETIVLI) || !rs1_x0_q) ? CW'(avl_q) : vlmax_w;
    vill_d  = nvt.vill | nvt.rsvd | new_bad
            | (keep & (vill_q | old_bad | (old_vlmax != new_vlmax)));
    vl_d    = keep ? vl_q : ((avl_w < vlmax_w) ? VL_BITS'(avl_w) : new_vlmax);
    vsew_d  = nvt.vsew;
    vlmul_d = nvt.vlmul;
    vta_d   = nvt.vta;
    vma_d   = nvt.vma;
    if (vill_d) begin
      vl_d    = '0;
      vsew_d  = '0;
      vlmul_d = '0;
      vta_d   = 1'b0;
      vma_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vl_q    <= '0;
      vsew_q  <= '0;
      vlmul_q <= '0;
      vta_q   <= 1'b0;
      vma_q   <= 1'b0;
      vill_q  <= 1'b1;
    end else if (state_q == ST_CALC) begin
      vl_q    <= vl_d;
      vsew_q  <= vsew_d;
      vlmul_q <= vlmul_d;
      vta_q   <= vta_d;
      vma_q   <= vma_d;
      vill_q  <= vill_d;
    end
  end

  assign vl      = vl_q;
  assign vsew    = vsew_q;
  assign vlmul   = vlmul_q;
  assign vta     = vta_q;
  assign vma     = vma_q;
  assign vill    = vill_q;
  assign resp_vl = XLEN'(vl_q);

endmodule

// File: tb/tb_vcfg_ctrl.sv
// Directed bench for vcfg_ctrl at VLEN=1024, ELEN=64, fractional LMUL enabled.
module tb_vcfg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_type;
  logic        req_rs1_x0, req_rd_x0;
  logic [31:0] req_avl, req_vtype;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_vl;
  logic        cfg_busy;
  logic [10:0] vl;
  logic [2:0]  vsew, vlmul;
  logic        vta, vma, vill;

  int n_chk = 0;
  int n_fail = 0;

  vcfg_ctrl #(.XLEN(32), .VLEN(1024), .ELEN(64), .FRAC_LMUL_EN(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_rs1_x0(req_rs1_x0), .req_rd_x0(req_rd_x0),
    .req_avl(req_avl), .req_vtype(req_vtype),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_vl(resp_vl),
    .cfg_busy(cfg_busy), .vl(vl), .vsew(vsew), .vlmul(vlmul),
    .vta(vta), .vma(vma), .vill(vill));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the CALC cycle.
  task automatic send(input logic [1:0] t, input logic r1x0, input logic rdx0,
                      input logic [31:0] avl, input logic [31:0] vt);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    req_type = t; req_rs1_x0 = r1x0; req_rd_x0 = rdx0;
    req_avl = avl; req_vtype = vt; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("calc_busy", 32'(cfg_busy), 32'd1);
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_type = 2'b00; req_rs1_x0 = 1'b0; req_rd_x0 = 1'b0;
    req_avl = '0; req_vtype = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_vl", 32'(vl), 32'd0);
    chk("rst_vill", 32'(vill), 32'd1);
    chk("rst_vsew", 32'(vsew), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // vsetvli avl=100 e32 m1 ta -> vl=32
    send(2'b00, 1'b0, 1'b0, 32'd100, 32'h50);
    @(negedge clk);
    chk("e32m1_vl", 32'(vl), 32'd32);
    chk("e32m1_vsew", 32'(vsew), 32'd2);
    chk("e32m1_vta", 32'(vta), 32'd1);
    chk("e32m1_vill", 32'(vill), 32'd0);
    chk("e32m1_resp_valid", 32'(resp_valid), 32'd1);
    chk("e32m1_resp_vl", resp_vl, 32'd32);
    chk("e32m1_req_ready", 32'(req_ready), 32'd0);
    ack();
    chk("ack_idle", 32'(req_ready), 32'd1);

    // e8 m8: VLMAX = 1024
    send(2'b00, 1'b0, 1'b0, 32'd2000, 32'h03);
    @(negedge clk);
    chk("e8m8_vl", 32'(vl), 32'd1024);
    chk("e8m8_resp_vl", resp_vl, 32'd1024);
    ack();
    send(2'b01, 1'b0, 1'b1, 32'h8000_0000, 32'h03);
    @(negedge clk);
    chk("e8m8_big_vl", 32'(vl), 32'd1024);
    chk("rdx0_no_resp", 32'(resp_valid), 32'd0);
    chk("rdx0_req_ready", 32'(req_ready), 32'd1);

    // vsetivli uimm=5 e16 mf2 -> VLMAX 32, vl 5
    send(2'b11, 1'b1, 1'b0, 32'd5, 32'h0F);
    @(negedge clk);
    chk("ivli_vl", 32'(vl), 32'd5);
    chk("ivli_vlmul", 32'(vlmul), 32'd7);
    chk("ivli_vill", 32'(vill), 32'd0);
    ack();

    // rs1=x0, rd!=x0, e16 m1 -> vl = VLMAX = 64
    send(2'b00, 1'b1, 1'b0, 32'd0, 32'h08);
    @(negedge clk);
    chk("x0_vlmax_vl", 32'(vl), 32'd64);
    chk("x0_vlmax_resp_vl", resp_vl, 32'd64);
    ack();

    // rs1=x0, rd=x0, e32 m2: same VLMAX 64 -> vl kept
    send(2'b00, 1'b1, 1'b1, 32'd0, 32'h11);
    @(negedge clk);
    chk("keep_vl", 32'(vl), 32'd64);
    chk("keep_vlmul", 32'(vlmul), 32'd1);
    chk("keep_vill", 32'(vill), 32'd0);

    // rs1=x0, rd=x0, e32 m1: VLMAX changes to 32 -> vill
    send(2'b00, 1'b1, 1'b1, 32'd0, 32'h10);
    @(negedge clk);
    chk("chg_vill", 32'(vill), 32'd1);
    chk("chg_vl", 32'(vl), 32'd0);
    chk("chg_vsew", 32'(vsew), 32'd0);

    // vsetvl avl=7 e16 m1 ma
    send(2'b10, 1'b0, 1'b0, 32'd7, 32'h88);
    @(negedge clk);
    chk("vsetvl_vl", 32'(vl), 32'd7);
    chk("vsetvl_vma", 32'(vma), 32'd1);
    chk("vsetvl_vsew", 32'(vsew), 32'd1);
    ack();

    // e64 mf8 illegal
    send(2'b00, 1'b0, 1'b0, 32'd10, 32'h1D);
    @(negedge clk);
    chk("e64mf8_vill", 32'(vill), 32'd1);
    chk("e64mf8_vl", 32'(vl), 32'd0);
    chk("e64mf8_resp_vl", resp_vl, 32'd0);
    ack();

    send(2'b00, 1'b0, 1'b1, 32'd10, 32'h04);
    @(negedge clk);
    chk("lmul_rsvd_vill", 32'(vill), 32'd1);

    send(2'b00, 1'b0, 1'b1, 32'd10, 32'h110);
    @(negedge clk);
    chk("bit8_vill", 32'(vill), 32'd1);

    send(2'b00, 1'b0, 1'b1, 32'd10, 32'h8000_0010);
    @(negedge clk);
    chk("bit31_vill", 32'(vill), 32'd1);

    // Back-pressure: response held, new request must wait
    send(2'b00, 1'b0, 1'b0, 32'd20, 32'h00);
    @(negedge clk);
    req_type = 2'b00; req_rs1_x0 = 1'b0; req_rd_x0 = 1'b1;
    req_avl = 32'd9; req_vtype = 32'h00; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_resp_valid", 32'(resp_valid), 32'd1);
      chk("hold_resp_vl", resp_vl, 32'd20);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_vl", 32'(vl), 32'd20);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("post_ack_req_ready", 32'(req_ready), 32'd1);
    chk("post_ack_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("held_req_busy", 32'(cfg_busy), 32'd1);
    @(negedge clk);
    chk("held_req_vl", 32'(vl), 32'd9);

    // Reset in CALC
    send(2'b00, 1'b0, 1'b0, 32'd50, 32'h10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_calc_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_calc_vill", 32'(vill), 32'd1);
    chk("rst_calc_vl", 32'(vl), 32'd0);
    chk("rst_calc_req_ready", 32'(req_ready), 32'd1);
    chk("rst_calc_busy", 32'(cfg_busy), 32'd0);

    // Reset in RESP
    send(2'b00, 1'b0, 1'b0, 32'd50, 32'h10);
    @(negedge clk);
    chk("pre_rst_resp_valid", 32'(resp_valid), 32'd1);
    chk("pre_rst_vl", 32'(vl), 32'd32);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_resp_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_vill", 32'(vill), 32'd1);
    chk("rst_resp_vl", 32'(vl), 32'd0);
    chk("rst_resp_req_ready", 32'(req_ready), 32'd1);

    // Reset together with req_valid: request is dropped
    req_type = 2'b00; req_rs1_x0 = 1'b0; req_rd_x0 = 1'b0;
    req_avl = 32'd3; req_vtype = 32'h00; req_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    chk("rst_req_busy", 32'(cfg_busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("rst_req_vl", 32'(vl), 32'd0);
    chk("rst_req_no_resp", 32'(resp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
